// File: rtl/srrc_coef_ctrl.sv
// Double-buffered coefficient bank for a 9-tap SRRC filter: the shadow bank is edited
// freely and swapped into the active bank on a sample strobe. Optional: SRRC_COEF_READBACK_EN.
module srrc_coef_ctrl (
  input  logic                clk,
  input  logic                reset,
  input  logic                sam_clk,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_addr,
  input  logic signed [17:0]  wr_data,
  input  logic                commit,
  input  logic                revert,
  output logic [161:0]        coef_flat,
  output logic                swap_done,
  output logic                dirty,
  output logic                pend,
`ifdef SRRC_COEF_READBACK_EN
  input  logic [3:0]          rd_addr,
  output logic signed [17:0]  rd_data,
`endif
  output logic                err_addr
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t state_reg, state_next;

  logic signed [17:0] active [0:8];
  logic signed [17:0] shadow [0:8];

  logic wr_fire, addr_ok, do_commit, do_revert, do_swap, do_write, do_err;

  function automatic logic signed [17:0] dflt(input int k);
    case (k)
      0:       dflt = 18'sd3259;
      1:       dflt = -18'sd3378;
      2:       dflt = -18'sd10461;
      3:       dflt = -18'sd12207;
      4:       dflt = -18'sd3946;
      5:       dflt = 18'sd14611;
      6:       dflt = 18'sd38196;
      7:       dflt = 18'sd57937;
      8:       dflt = 18'sd65624;
      default: dflt = 18'sd0;
    endcase
  endfunction

  // The filter reads the active bank straight from its flops; it only moves on a swap.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_flat
      assign coef_flat[18*gi +: 18] = active[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    addr_ok    = (wr_addr <= 4'd8);
    wr_fire    = wr_valid && (state_reg != PEND);
    do_commit  = commit && (state_reg != PEND);
    // commit outranks revert when both arrive together
    do_revert  = revert && !commit && (state_reg != PEND);
    do_swap    = sam_clk && (state_reg == PEND);
    do_write   = wr_fire && addr_ok && !do_revert;
    do_err     = wr_fire && !addr_ok && !do_revert;

    case (state_reg)
      IDLE, LOAD: begin
        if (do_commit)
          state_next = PEND;
        else if (do_revert)
          state_next = IDLE;
        else if (do_write)
          state_next = LOAD;
      end
      PEND: begin
        if (do_swap)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      wr_ready  <= 1'b1;
      dirty     <= 1'b0;
      pend      <= 1'b0;
      swap_done <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_ready  <= (state_next != PEND);
      dirty     <= (state_next == LOAD);
      pend      <= (state_next == PEND);
      swap_done <= do_swap;
      if (do_swap)
        err_addr <= 1'b0;
      else if (do_err)
        err_addr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        active[i] <= dflt(i);
        shadow[i] <= dflt(i);
      end
    end else begin
      if (do_swap) begin
        for (int i = 0; i < 9; i++)
          active[i] <= shadow[i];
      end
      if (do_revert) begin
        for (int i = 0; i < 9; i++)
          shadow[i] <= active[i];
      end else if (do_write) begin
        shadow[wr_addr] <= wr_data;
      end
    end
  end

`ifdef SRRC_COEF_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data <= 18'sd0;
    else if (rd_addr <= 4'd8)
      rd_data <= active[rd_addr];
    else
      rd_data <= 18'sd0;
  end
`endif

endmodule

// File: doc/srrc_coef_ctrl.md
SRRC_COEF_CTRL -- requirements
Module: srrc_coef_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-002 SHALL have ports: sam_clk in 1, one-cycle sample strobe, shared with the filter.
REQ-003 SHALL have ports: wr_valid in 1; wr_ready out 1; wr_addr in 4, tap index 0..8; wr_data in 18 signed, coefficient value.
REQ-004 SHALL have ports: commit in 1, request to swap the shadow bank in; revert in 1, discard the shadow bank.
REQ-005 SHALL have ports: coef_flat out 162, active bank, with b[k] at bits [18k+17:18k].
REQ-006 SHALL have ports: swap_done out 1, one-cycle pulse; dirty out 1; pend out 1; err_addr out 1, sticky.

Function
REQ-007 SHALL hold two 9x18 banks, active and shadow; coef_flat SHALL be registered directly from active.
REQ-008 SHALL implement the FSM states IDLE (shadow equals active), LOAD (shadow modified) and PEND (swap requested).
REQ-009 Write handshake: wr_ready=1 in IDLE/LOAD and 0 in PEND; a write completes when wr_valid&wr_ready are high at the clk edge.
REQ-010 A completed write with wr_addr<=8 SHALL update shadow[wr_addr] and move the FSM to LOAD.
REQ-011 A completed write with wr_addr>8 SHALL leave shadow unchanged and set err_addr=1 at the next edge.
REQ-012 commit in IDLE/LOAD SHALL move the FSM to PEND at the next edge; pend and wr_ready SHALL reflect PEND from that edge.
REQ-013 When a write and commit arrive in the same cycle, the write SHALL be applied first, then the FSM SHALL enter PEND.
REQ-014 In PEND, sam_clk=1 SHALL copy shadow to active at that edge, clear err_addr, pulse swap_done for exactly that cycle, and return the FSM to IDLE.
REQ-015 The swap SHALL use only a sam_clk that occurs while the FSM is already in PEND; a sam_clk coincident with commit SHALL NOT swap.
REQ-016 commit in PEND SHALL be ignored; revert in PEND SHALL be ignored.
REQ-017 revert in IDLE/LOAD SHALL copy active to shadow and move the FSM to IDLE; a write in the same cycle SHALL be discarded without setting err_addr.
REQ-018 When revert and commit arrive in the same cycle, commit SHALL win and revert SHALL be ignored.
REQ-019 dirty SHALL be 1 exactly in LOAD and pend SHALL be 1 exactly in PEND, both registered.
REQ-020 coef_flat SHALL change only on a sam_clk edge, so the filter sees a complete bank per sample and never a mix of old and new taps.

Reset
REQ-021 reset SHALL asynchronously load both banks with the defaults b0..b8 = 3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624.
REQ-022 During reset: FSM=IDLE, wr_ready=1, swap_done=0, dirty=0, pend=0, err_addr=0, coef_flat=defaults.
REQ-023 reset asserted in any state, including PEND, SHALL abort the pending swap and discard the shadow bank contents.

Configuration
REQ-024 Macro SRRC_COEF_READBACK_EN defined: SHALL add rd_addr in 4 and rd_data out 18 signed; rd_data SHALL be active[rd_addr] registered with 1-cycle latency, 0 for rd_addr>8, and 0 at reset.
REQ-025 Macro SRRC_COEF_READBACK_EN undefined: the rd_addr and rd_data ports and their logic SHALL be absent, with no other behavioural change.

Verification
REQ-026 Release reset -> coef_flat b0=3259, b4=-3946, b8=65624; wr_ready=1; dirty=0.
REQ-027 Write addr8=60000, commit, hold sam_clk low 10 cycles -> b8=65624, wr_ready=0, pend=1; pulse sam_clk -> b8=60000 after that edge, swap_done high 1 cycle, FSM=IDLE.
REQ-028 Write addr9=123, commit, sam_clk -> err_addr=1 until the swap, coef_flat unchanged, err_addr=0 after the swap.
REQ-029 Write addr3=-1, revert, commit, sam_clk -> b3=-12207, dirty=0.
REQ-030 Write addr0=7 with commit and sam_clk all in one cycle -> no swap on that edge; the next sam_clk swaps and b0=7.
REQ-031 Write addr5=0, commit, assert reset in PEND -> b5=14611, pend=0; later sam_clk produces no swap_done. With SRRC_COEF_READBACK_EN: rd_addr=7 -> rd_data=57937 one cycle later.
